// File: rtl/key_repeat.sv
// Press-pulse and auto-repeat generator for debounced key levels, one FSM per channel.
// Optional repeat acceleration is compiled in with `define KEY_REPEAT_ACCEL_EN.
module key_repeat #(
    parameter int              N_KEYS      = 4,
    parameter int              CLK_HZ      = 50000000,
    parameter int              DELAY_MS    = 300,
    parameter int              RATE_MS     = 100,
    parameter logic [N_KEYS-1:0] REPEAT_MASK = 4'b0111,
    parameter int              ACCEL_COUNT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_pulse,
    output logic [N_KEYS-1:0] key_held,
    output logic [N_KEYS-1:0] repeat_active
);

    localparam int DELAY_RAW = CLK_HZ / 1000 * DELAY_MS;
    localparam int RATE_RAW  = CLK_HZ / 1000 * RATE_MS;
    localparam int DELAY_CYC = (DELAY_RAW < 1) ? 1 : DELAY_RAW;
    localparam int RATE_CYC  = (RATE_RAW < 1) ? 1 : RATE_RAW;
    localparam int MAX_CYC   = (DELAY_CYC > RATE_CYC) ? DELAY_CYC : RATE_CYC;
    localparam int CW        = (MAX_CYC < 1) ? 1 : $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0] DELAY_LOAD = CW'(DELAY_CYC - 1);
    localparam logic [CW-1:0] RATE_LOAD  = CW'(RATE_CYC - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_REPEAT = 2'd2;
    localparam logic [1:0] S_HOLD   = 2'd3;

    logic [1:0]    state [N_KEYS];
    logic [CW-1:0] cnt   [N_KEYS];
    logic [CW-1:0] reload[N_KEYS];

`ifdef KEY_REPEAT_ACCEL_EN
    localparam int FAST_CYC = ((RATE_CYC / 2) < 1) ? 1 : (RATE_CYC / 2);
    localparam logic [CW-1:0] FAST_LOAD = CW'(FAST_CYC - 1);
    localparam int AW = (ACCEL_COUNT < 1) ? 1 : $clog2(ACCEL_COUNT + 1);
    localparam logic [AW-1:0] ACCEL_SAT = AW'(ACCEL_COUNT);

    logic [AW-1:0] acc_cnt [N_KEYS];

    // Reload is chosen from pulses already emitted, so the ACCEL_COUNT-th
    // and earlier repeat intervals keep the normal rate.
    always_comb begin
        for (int unsigned i = 0; i < N_KEYS; i++) begin
            reload[i] = (acc_cnt[i] >= ACCEL_SAT) ? FAST_LOAD : RATE_LOAD;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < N_KEYS; i++) begin
                acc_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N_KEYS; i++) begin
                if (!key_level[i]) begin
                    acc_cnt[i] <= '0;
                end else if ((state[i] == S_WAIT || state[i] == S_REPEAT) &&
                             cnt[i] == '0 && acc_cnt[i] < ACCEL_SAT) begin
                    acc_cnt[i] <= acc_cnt[i] + 1'b1;
                end
            end
        end
    end
`else
    always_comb begin
        for (int unsigned i = 0; i < N_KEYS; i++) begin
            reload[i] = RATE_LOAD;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_pulse <= '0;
            key_held  <= '0;
            for (int unsigned i = 0; i < N_KEYS; i++) begin
                state[i] <= S_IDLE;
                cnt[i]   <= '0;
            end
        end else begin
            key_held <= key_level;
            for (int unsigned i = 0; i < N_KEYS; i++) begin
                key_pulse[i] <= 1'b0;
                case (state[i])
                    S_IDLE: begin
                        if (key_level[i]) begin
                            key_pulse[i] <= 1'b1;
                            cnt[i]       <= DELAY_LOAD;
                            state[i]     <= REPEAT_MASK[i] ? S_WAIT : S_HOLD;
                        end
                    end
                    S_WAIT, S_REPEAT: begin
                        // Release wins over a coincident expiry.
                        if (!key_level[i]) begin
                            state[i] <= S_IDLE;
                            cnt[i]   <= '0;
                        end else if (cnt[i] == '0) begin
                            key_pulse[i] <= 1'b1;
                            cnt[i]       <= reload[i];
                            state[i]     <= S_REPEAT;
                        end else begin
                            cnt[i] <= cnt[i] - 1'b1;
                        end
                    end
                    default: begin
                        if (!key_level[i]) begin
                            state[i] <= S_IDLE;
                            cnt[i]   <= '0;
                        end
                    end
                endcase
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < N_KEYS; i++) begin
            repeat_active[i] = (state[i] == S_REPEAT);
        end
    end

endmodule

// File: tb/tb_key_repeat.sv
// Self-checking bench for key_repeat: directed scenarios then random key activity,
// compared each cycle against a pulse-schedule model derived from elapsed hold time.
module tb_key_repeat;

    localparam int N      = 4;
    localparam int D      = 5;   // CLK_HZ=1000, DELAY_MS=5
    localparam int R      = 3;   // RATE_MS=3
    localparam int A      = 2;
    localparam int F      = 1;   // max(R/2,1)
    localparam logic [3:0] MASK = 4'b0111;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] key_level;
    logic [3:0] key_pulse;
    logic [3:0] key_held;
    logic [3:0] repeat_active;

    int total = 0;
    int bad   = 0;

    bit act   [N];
    int start [N];
    int edge_n = 0;
    logic [3:0] cur;

    key_repeat #(
        .N_KEYS     (4),
        .CLK_HZ     (1000),
        .DELAY_MS   (5),
        .RATE_MS    (3),
        .REPEAT_MASK(4'b0111),
        .ACCEL_COUNT(2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .key_level    (key_level),
        .key_pulse    (key_pulse),
        .key_held     (key_held),
        .repeat_active(repeat_active)
    );

    always #5 clk = ~clk;

    // Repeat pulse due after el edges of continuous hold (press pulse at el=0).
    function automatic bit is_rep(input int el);
        int x;
        if (el < D) return 1'b0;
        x = el - D;
`ifdef KEY_REPEAT_ACCEL_EN
        if (x <= R * A) return (x % R) == 0;
        return ((x - R * A) % F) == 0;
`else
        return (x % R) == 0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            act[i]   = 1'b0;
            start[i] = 0;
        end
    endtask

    task automatic step(input logic [3:0] lvl);
        logic [3:0] ep;
        logic [3:0] er;
        int el;
        key_level = lvl;
        @(posedge clk);
        edge_n++;
        ep = '0;
        er = '0;
        for (int i = 0; i < N; i++) begin
            if (!act[i]) begin
                if (lvl[i]) begin
                    act[i]   = 1'b1;
                    start[i] = edge_n;
                    ep[i]    = 1'b1;
                end
            end else if (!lvl[i]) begin
                act[i] = 1'b0;
            end else begin
                el    = edge_n - start[i];
                ep[i] = MASK[i] && is_rep(el);
                er[i] = MASK[i] && (el >= D);
            end
        end
        #1;
        chk("key_pulse", key_pulse, ep);
        chk("repeat_active", repeat_active, er);
        chk("key_held", key_held, lvl);
    endtask

    // Called just after an edge; reset pulse lies entirely between edges.
    task automatic mid_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_pulse", key_pulse, 4'b0000);
        chk("rst_repeat", repeat_active, 4'b0000);
        chk("rst_held", key_held, 4'b0000);
        model_reset();
        #1 rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        key_level = 4'b1111;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_pulse", key_pulse, 4'b0000);
        chk("reset_repeat", repeat_active, 4'b0000);
        chk("reset_held", key_held, 4'b0000);
        #3 rst = 1'b0;

        // Keys held through reset release: all pulse on the first edge.
        repeat (12) step(4'b1111);
        repeat (2) step(4'b0000);

        // Left held 20 cycles.
        repeat (20) step(4'b0001);
        repeat (2) step(4'b0000);

        // Right short tap.
        repeat (3) step(4'b0010);
        repeat (2) step(4'b0000);

        // Down released exactly at counter expiry, re-pressed next cycle.
        repeat (5) step(4'b0100);
        step(4'b0000);
        repeat (7) step(4'b0100);
        repeat (2) step(4'b0000);

        // Rotate held long.
        repeat (50) step(4'b1000);
        step(4'b0000);

        // Left and rotate on the same edge.
        repeat (10) step(4'b1001);
        step(4'b0000);

        // Reset mid-train with left still held afterwards.
        repeat (10) step(4'b0001);
        mid_reset();
        repeat (15) step(4'b0001);
        repeat (2) step(4'b0000);

        // Random activity with occasional mid-run resets.
        cur = 4'b0000;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(7) == 0) cur[i] = ~cur[i];
            end
            step(cur);
            if ($urandom_range(99) == 0) mid_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
